display_scan_ctrl: RTL and testbench

- Scan sequencer and update controller for the 4-digit, 8-phase seven-segment display datapath.
- Generates the 3-bit phase code (byte_status) at a programmable dwell rate.
- Supplies a frame-stable 12-bit display word: two 6-bit fields, low = [5:0], high = [11:6].
- Accepts new values from the timekeeping logic through a req/ack handshake and produces a per-digit blink mask for set mode.

---
 rtl/display_scan_if.sv | 14 +
 rtl/display_scan_ctrl.sv | 116 +++++++++++
 tb/tb_display_scan_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/display_scan_if.sv
// Update handshake between the timekeeping logic and the scan controller.
//   data_in    : candidate display word, [5:0] low field, [11:6] high field
//   update_req : level request, held by the master until update_ack
//   update_ack : one-cycle pulse from the slave, data_in was captured
interface display_scan_if;
    localparam int unsigned WORD_W = 12;

    logic [WORD_W-1:0] data_in;
    logic              update_req;
    logic              update_ack;

    modport master (output data_in, output update_req, input update_ack);
    modport slave  (input data_in, input update_req, output update_ack);
endinterface

// File: rtl/display_scan_ctrl.sv
// Scan sequencer and update controller for a 4-digit, 8-phase seven-segment
// display datapath. Steps a 3-bit phase code at a programmable dwell,
// latches a frame-stable display word and produces a per-digit blink mask.
// Ports:
//   clock       : system clock, all state updates on the rising edge
//   reset       : synchronous active-low reset
//   enable      : 1 = scanning runs, 0 = all state holds
//   upd         : update handshake (data_in / update_req / update_ack)
//   blink_sel   : bit0 blinks the low-field digits, bit1 the high-field digits
//   byte_status : current scan phase 0..7
//   data_show   : latched display word, fields clamped to 0..59
//   digit_mask  : per-digit enable, bit n gates digit n
//   frame_start : one-cycle pulse when byte_status returns to 0
module display_scan_ctrl #(
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    display_scan_if.slave       upd,
    input  logic [1:0]          blink_sel,
    output logic [2:0]          byte_status,
    output logic [11:0]         data_show,
    output logic [3:0]          digit_mask,
    output logic                frame_start
);
    localparam int unsigned PS_W      = 10;
    localparam int unsigned FC_W      = 8;
    localparam int unsigned PHASE_W   = 3;
    localparam int unsigned FIELD_W   = 6;
    localparam int unsigned WORD_W    = 2 * FIELD_W;
    localparam int unsigned FIELD_MAX = 59;

    logic [PS_W-1:0]    presc_q, presc_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [FC_W-1:0]    frame_q, frame_d;
    logic               blink_q, blink_d;
    logic [WORD_W-1:0]  show_q, show_d;
    logic [3:0]         mask_q, mask_d;
    logic               ack_q, ack_d;
    logic               fs_q, fs_d;

    // Saturate one field to the largest legal minutes/seconds value.
    function automatic logic [FIELD_W-1:0] clamp_field(input logic [FIELD_W-1:0] f);
        return (f > FIELD_W'(FIELD_MAX)) ? FIELD_W'(FIELD_MAX) : f;
    endfunction

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            presc_q <= '0;
            phase_q <= '0;
            frame_q <= '0;
            blink_q <= 1'b1;
            show_q  <= '0;
            mask_q  <= 4'b1111;
            ack_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            show_q  <= show_d;
            mask_q  <= mask_d;
            ack_q   <= ack_d;
            fs_q    <= fs_d;
        end
    end

    // Next-state: prescaler, phase, and all frame-boundary work.
    always_comb begin
        presc_d = presc_q;
        phase_d = phase_q;
        frame_d = frame_q;
        blink_d = blink_q;
        show_d  = show_q;
        mask_d  = mask_q;
        ack_d   = 1'b0;
        fs_d    = 1'b0;

        if (enable) begin
            if (presc_q == PS_W'(PRESCALE - 1)) begin
                presc_d = '0;
                phase_d = phase_q + PHASE_W'(1);
                // 7 -> 0 transition is the only point where display state moves.
                if (phase_q == PHASE_W'(7)) begin
                    fs_d = 1'b1;
                    if (upd.update_req) begin
                        show_d = {clamp_field(upd.data_in[WORD_W-1:FIELD_W]),
                                  clamp_field(upd.data_in[FIELD_W-1:0])};
                        ack_d  = 1'b1;
                    end
                    if (frame_q == FC_W'(BLINK_FRAMES - 1)) begin
                        frame_d = '0;
                        blink_d = ~blink_q;
                    end else begin
                        frame_d = frame_q + FC_W'(1);
                    end
                    // Mask uses the post-boundary blink phase.
                    mask_d[1:0] = (blink_sel[0] && !blink_d) ? 2'b00 : 2'b11;
                    mask_d[3:2] = (blink_sel[1] && !blink_d) ? 2'b00 : 2'b11;
                end
            end else begin
                presc_d = presc_q + PS_W'(1);
            end
        end
    end

    assign byte_status    = phase_q;
    assign data_show      = show_q;
    assign digit_mask     = mask_q;
    assign frame_start    = fs_q;
    assign upd.update_ack = ack_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;
    localparam int unsigned PRESCALE     = 4;
    localparam int unsigned BLINK_FRAMES = 2;
    localparam int unsigned FRAME_CYC    = PRESCALE * 8;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  blink_sel;
    logic [2:0]  byte_status;
    logic [11:0] data_show;
    logic [3:0]  digit_mask;
    logic        frame_start;

    display_scan_if u_if ();

    display_scan_ctrl #(
        .PRESCALE     (PRESCALE),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clock       (clk),
        .reset       (reset),
        .enable      (enable),
        .upd         (u_if.slave),
        .blink_sel   (blink_sel),
        .byte_status (byte_status),
        .data_show   (data_show),
        .digit_mask  (digit_mask),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: enabled edges since reset, frame counter, blink phase.
    int          n_cyc    = 0;
    int          fc       = 0;
    logic        bp       = 1'b1;
    logic [3:0]  exp_mask = 4'b1111;
    logic [11:0] exp_show = 12'h000;
    logic        exp_fs   = 1'b0;
    logic        exp_ack  = 1'b0;
    logic [11:0] sb_q[$];

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model from inputs seen at the edge, then check at negedge.
    task automatic step();
        logic s_rst, s_en, s_req;
        logic [1:0] s_sel;
        @(posedge clk);
        s_rst = reset; s_en = enable; s_req = u_if.update_req; s_sel = blink_sel;
        exp_fs = 1'b0;
        if (!s_rst) begin
            n_cyc = 0; fc = 0; bp = 1'b1; exp_mask = 4'b1111; exp_show = 12'h000;
        end else if (s_en) begin
            n_cyc++;
            if (n_cyc % FRAME_CYC == 0) begin
                exp_fs = 1'b1;
                if (fc == BLINK_FRAMES - 1) begin fc = 0; bp = ~bp; end
                else fc++;
                exp_mask[1:0] = (s_sel[0] && !bp) ? 2'b00 : 2'b11;
                exp_mask[3:2] = (s_sel[1] && !bp) ? 2'b00 : 2'b11;
            end
        end
        exp_ack = exp_fs && s_req;
        @(negedge clk);
        chk("byte_status", 12'(byte_status), 12'((n_cyc / PRESCALE) % 8));
        chk("frame_start", 12'(frame_start), 12'(exp_fs));
        chk("update_ack", 12'(u_if.update_ack), 12'(exp_ack));
        chk("digit_mask", 12'(digit_mask), 12'(exp_mask));
        if (u_if.update_ack === 1'b1) begin
            if (sb_q.size() == 0) chk("sb_nonempty", 12'(0), 12'(1));
            else exp_show = sb_q.pop_front();
        end
        chk("data_show", data_show, exp_show);
    endtask

    // Raise a request mid-frame and hold it until acked (bounded).
    task automatic request(input logic [11:0] din, input logic [11:0] expv);
        bit got = 0;
        sb_q.push_back(expv);
        u_if.data_in    = din;
        u_if.update_req = 1'b1;
        for (int i = 0; i < 2 * FRAME_CYC && !got; i++) begin
            step();
            if (u_if.update_ack === 1'b1) got = 1;
        end
        chk("ack_seen", 12'(got), 12'(1));
        chk("load_value", data_show, expv);
        chk("ack_with_fs", 12'(frame_start), 12'(1));
        chk("ack_phase0", 12'(byte_status), 12'(0));
        u_if.update_req = 1'b0;
    endtask

    task automatic wait_frame();
        bit got = 0;
        for (int i = 0; i < 2 * FRAME_CYC && !got; i++) begin
            step();
            if (frame_start === 1'b1) got = 1;
        end
        chk("frame_seen", 12'(got), 12'(1));
    endtask

    initial begin
        int cnt;
        bit hit;
        logic [3:0] blink_exp [8];
        blink_exp = '{4'b1111, 4'b1100, 4'b1100, 4'b1111,
                      4'b1111, 4'b0011, 4'b0011, 4'b1111};

        reset = 1'b0; enable = 1'b0; blink_sel = 2'b00;
        u_if.data_in = 12'h000; u_if.update_req = 1'b0;
        @(negedge clk);
        step(); step();
        chk("rst_status", 12'(byte_status), 12'(0));
        chk("rst_show", data_show, 12'h000);
        chk("rst_mask", 12'(digit_mask), 12'hF);
        chk("rst_fs", 12'(frame_start), 12'(0));

        // Free-running scan: two frame pulses in 64 cycles.
        reset = 1'b1; enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            step();
            if (frame_start === 1'b1) cnt++;
        end
        chk("fs_count", 12'(cnt), 12'(2));

        // Loads: raised 10 cycles into a frame.
        for (int i = 0; i < 10; i++) step();
        request({6'd12, 6'd34}, {6'd12, 6'd34});
        for (int i = 0; i < 2 * FRAME_CYC + 6; i++) step();
        chk("show_held", data_show, {6'd12, 6'd34});
        request(12'hFFF, 12'hEFB);
        for (int i = 0; i < 5; i++) step();
        request({6'd5, 6'd60}, 12'h17B);

        // Blink: start from a clean blink phase, sel change lands mid-frame.
        reset = 1'b0; step(); reset = 1'b1;
        blink_sel = 2'b01;
        for (int f = 0; f < 8; f++) begin
            wait_frame();
            chk("blink_mask", 12'(digit_mask), 12'(blink_exp[f]));
            if (f == 3) blink_sel = 2'b10;
        end
        blink_sel = 2'b00;

        // Freeze one cycle into phase 3 with a pending request.
        hit = 0;
        for (int i = 0; i < 2 * FRAME_CYC && !hit; i++) begin
            step();
            if (byte_status == 3'd3 && n_cyc % PRESCALE == 1) hit = 1;
        end
        chk("reach_p3", 12'(hit), 12'(1));
        enable = 1'b0; u_if.data_in = 12'h123; u_if.update_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("frozen_p3", 12'(byte_status), 12'(3));
        end
        u_if.update_req = 1'b0; enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8 && byte_status == 3'd3; i++) begin step(); cnt++; end
        chk("p3_remaining", 12'(cnt), 12'(3));

        // Reset pulse in phase 5 with a request pending.
        hit = 0;
        for (int i = 0; i < 2 * FRAME_CYC && !hit; i++) begin
            step();
            if (byte_status == 3'd5) hit = 1;
        end
        chk("reach_p5", 12'(hit), 12'(1));
        step();
        u_if.data_in = 12'h2AB; u_if.update_req = 1'b1; reset = 1'b0;
        step();
        chk("midrst_status", 12'(byte_status), 12'(0));
        chk("midrst_show", data_show, 12'h000);
        chk("midrst_ack", 12'(u_if.update_ack), 12'(0));
        chk("midrst_mask", 12'(digit_mask), 12'hF);
        reset = 1'b1; u_if.update_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8 && byte_status == 3'd0; i++) begin step(); cnt++; end
        chk("p0_dwell", 12'(cnt), 12'(PRESCALE));
        for (int i = 0; i < FRAME_CYC; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
